// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC job scheduler: FSM states, job modes and defaults.
package cordic_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_DONE
  } sched_state_t;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } cordic_mode_t;

  localparam int unsigned CORDIC_ITERS = 11;
  localparam int unsigned ITER_W       = 4;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Requester arbiter for the CORDIC scheduler: one-hot grant from a request vector.
// CORDIC_SCHED_RR_EN selects round-robin; otherwise fixed priority, lowest index wins.
module cordic_rr_arbiter import cordic_pkg::*; #(
  parameter int unsigned NREQ = 4
) (
`ifdef CORDIC_SCHED_RR_EN
  input  logic            clk,
  input  logic            reset,
  input  logic            i_adv,
`endif
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt
);

`ifdef CORDIC_SCHED_RR_EN
  localparam int unsigned PW = idx_w(NREQ);

  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_ptr_nxt;
  logic [NREQ-1:0] w_hi;
  logic [NREQ-1:0] w_pool;
  logic            w_found;

  // Requests at or above the pointer take precedence; otherwise wrap to the lowest index.
  always_comb begin
    w_hi = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_hi[k] = i_req[k] && (PW'(k) >= r_ptr);
    end
    w_pool    = (|w_hi) ? w_hi : i_req;
    o_gnt     = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_pool[k] && !w_found) begin
        o_gnt[k]  = 1'b1;
        w_ptr_nxt = PW'((k + 1) % NREQ);
        w_found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= w_ptr_nxt;
    end
  end
`else
  logic w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (i_req[k] && !w_found) begin
        o_gnt[k] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one iterative CORDIC datapath among NREQ requesters: arbitrate, load, iterate, respond.
// Define CORDIC_SCHED_RR_EN for round-robin arbitration (fixed priority otherwise).
module cordic_scheduler import cordic_pkg::*; #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned W     = 16,
  parameter int unsigned ITERS = CORDIC_ITERS
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NREQ-1:0]                          req_valid,
  output logic [NREQ-1:0]                          req_ready,
  input  logic [NREQ*W-1:0]                        req_x,
  input  logic [NREQ*W-1:0]                        req_y,
  input  logic [NREQ*W-1:0]                        req_z,
  input  logic [NREQ-1:0]                          req_mode,
  output logic                                     dp_sel,
  output logic [ITER_W-1:0]                        dp_iter,
  output logic                                     dp_mode,
  output logic [W-1:0]                             dp_x,
  output logic [W-1:0]                             dp_y,
  output logic [W-1:0]                             dp_z,
  input  logic [W-1:0]                             dp_xo,
  input  logic [W-1:0]                             dp_yo,
  input  logic [W-1:0]                             dp_zo,
  output logic                                     rsp_valid,
  input  logic                                     rsp_ready,
  output logic [(NREQ > 1 ? $clog2(NREQ) : 1)-1:0] rsp_id,
  output logic [W-1:0]                             rsp_x,
  output logic [W-1:0]                             rsp_y,
  output logic [W-1:0]                             rsp_z,
  output logic                                     busy
);

  localparam int unsigned IDW = idx_w(NREQ);

  sched_state_t      r_state;
  sched_state_t      w_state_nxt;
  logic [ITER_W-1:0] r_iter;
  logic              w_last;
  logic              w_accept;
  logic [NREQ-1:0]   w_gnt;
  logic [IDW-1:0]    w_gnt_id;
  logic [W-1:0]      w_sel_x;
  logic [W-1:0]      w_sel_y;
  logic [W-1:0]      w_sel_z;
  logic              w_sel_mode;

  logic [W-1:0]      r_x;
  logic [W-1:0]      r_y;
  logic [W-1:0]      r_z;
  cordic_mode_t      r_mode;
  logic [IDW-1:0]    r_id;
  logic [W-1:0]      r_rx;
  logic [W-1:0]      r_ry;
  logic [W-1:0]      r_rz;

  cordic_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
`ifdef CORDIC_SCHED_RR_EN
    .clk   (clk),
    .reset (reset),
    .i_adv (w_accept),
`endif
    .i_req (req_valid),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_sel_x    = '0;
    w_sel_y    = '0;
    w_sel_z    = '0;
    w_sel_mode = 1'b0;
    w_gnt_id   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_gnt[k]) begin
        w_sel_x    = req_x[k*W +: W];
        w_sel_y    = req_y[k*W +: W];
        w_sel_z    = req_z[k*W +: W];
        w_sel_mode = req_mode[k];
        w_gnt_id   = IDW'(k);
      end
    end
  end

  assign w_last = (r_state == S_ITER) && (r_iter == ITER_W'(ITERS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant is suppressed while reset is held so nothing is accepted into an aborting FSM.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    dp_sel      = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (!reset && (|req_valid)) begin
          req_ready   = w_gnt;
          w_accept    = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_ITER;
      end
      S_ITER: begin
        dp_sel = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Counter returns to zero on the last iteration, so it reads 0 everywhere outside LOAD/ITER.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_iter <= '0;
    end else if (r_state == S_LOAD) begin
      r_iter <= ITER_W'(1);
    end else if (r_state == S_ITER) begin
      r_iter <= w_last ? '0 : r_iter + ITER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_mode <= MODE_ROT;
      r_id   <= '0;
    end else if (w_accept) begin
      r_x    <= w_sel_x;
      r_y    <= w_sel_y;
      r_z    <= w_sel_z;
      r_mode <= cordic_mode_t'(w_sel_mode);
      r_id   <= w_gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx <= '0;
      r_ry <= '0;
      r_rz <= '0;
    end else if (w_last) begin
      r_rx <= dp_xo;
      r_ry <= dp_yo;
      r_rz <= dp_zo;
    end
  end

  assign dp_iter = r_iter;
  assign dp_mode = r_mode;
  assign dp_x    = r_x;
  assign dp_y    = r_y;
  assign dp_z    = r_z;
  assign rsp_id  = r_id;
  assign rsp_x   = r_rx;
  assign rsp_y   = r_ry;
  assign rsp_z   = r_rz;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Scoreboard bench for cordic_scheduler: stimulus queues expected grants/responses, a negedge monitor checks them.
module tb_cordic_scheduler;
  import cordic_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned W     = 16;
  localparam int unsigned ITERS = 11;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x, req_y, req_z;
  logic [NREQ-1:0]   req_mode;
  logic              dp_sel;
  logic [3:0]        dp_iter;
  logic              dp_mode;
  logic [W-1:0]      dp_x, dp_y, dp_z;
  logic [W-1:0]      dp_xo, dp_yo, dp_zo;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_x, rsp_y, rsp_z;
  logic              busy;

  always #5 clk = ~clk;

  cordic_scheduler #(
    .NREQ  (NREQ),
    .W     (W),
    .ITERS (ITERS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_z     (req_z),
    .req_mode  (req_mode),
    .dp_sel    (dp_sel),
    .dp_iter   (dp_iter),
    .dp_mode   (dp_mode),
    .dp_x      (dp_x),
    .dp_y      (dp_y),
    .dp_z      (dp_z),
    .dp_xo     (dp_xo),
    .dp_yo     (dp_yo),
    .dp_zo     (dp_zo),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_x     (rsp_x),
    .rsp_y     (rsp_y),
    .rsp_z     (rsp_z),
    .busy      (busy)
  );

  // Stand-in datapath: a cheap function of operands and iteration index, so capture timing matters.
  always_comb begin
    if (!dp_sel) begin
      dp_xo = dp_x;
      dp_yo = dp_y;
      dp_zo = dp_z;
    end else begin
      dp_xo = dp_x + 16'(dp_iter);
      dp_yo = dp_y ^ 16'(dp_iter) ^ (dp_mode ? 16'h8000 : 16'h0000);
      dp_zo = dp_z - 16'(dp_iter);
    end
  end

  typedef struct {
    logic [3:0]  gnt;
    logic [15:0] x, y, z;
    logic        mode;
  } job_t;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] x, y, z;
  } rsp_t;

  job_t exp_job[$];
  rsp_t exp_rsp[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Final-iteration (index 10) result of the stand-in datapath.
  function automatic rsp_t model(input logic [1:0] id, input logic [15:0] x, input logic [15:0] y,
                                 input logic [15:0] z, input logic m);
    rsp_t r;
    r.id = id;
    r.x  = x + 16'd10;
    r.y  = y ^ 16'h000A ^ (m ? 16'h8000 : 16'h0000);
    r.z  = z - 16'd10;
    return r;
  endfunction

  logic [15:0] op_x[NREQ], op_y[NREQ], op_z[NREQ];
  logic        op_m[NREQ];

  task automatic set_ops(input int k, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] z, input logic m);
    op_x[k] = x; op_y[k] = y; op_z[k] = z; op_m[k] = m;
    req_x[k*W +: W] = x;
    req_y[k*W +: W] = y;
    req_z[k*W +: W] = z;
    req_mode[k]     = m;
  endtask

  task automatic expect_job(input int k, input bit with_rsp);
    job_t j;
    j.gnt = 4'(1 << k); j.x = op_x[k]; j.y = op_y[k]; j.z = op_z[k]; j.mode = op_m[k];
    exp_job.push_back(j);
    if (with_rsp) exp_rsp.push_back(model(2'(k), op_x[k], op_y[k], op_z[k], op_m[k]));
  endtask

  // ---------------- monitor ----------------
  int          cyc = 0, t_grant = 0, hs_cyc = 0, prev_gcyc = 0, mon_d = 0;
  bit          in_job = 0, prev_valid = 0, b2b_en = 0, b2b_have = 0, gap_en = 0;
  job_t        cur;
  rsp_t        got;
  logic [1:0]  pv_id;
  logic [15:0] pv_x, pv_y, pv_z;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      in_job     = 0;
      prev_valid = 0;
    end else begin
      chk("busy", 32'(busy), 32'(in_job));
      if (in_job) begin
        mon_d = cyc - t_grant;
        chk("ready_while_busy", 32'(req_ready), 32'd0);
        if (mon_d == 1) begin
          chk("load_sel", 32'(dp_sel), 32'd0);
          chk("load_iter", 32'(dp_iter), 32'd0);
        end else if (mon_d <= int'(ITERS)) begin
          chk("iter_sel", 32'(dp_sel), 32'd1);
          chk("iter_idx", 32'(dp_iter), 32'(mon_d - 1));
        end else begin
          chk("done_iter", 32'(dp_iter), 32'd0);
        end
        if (mon_d <= int'(ITERS)) begin
          chk("dp_x", 32'(dp_x), 32'(cur.x));
          chk("dp_y", 32'(dp_y), 32'(cur.y));
          chk("dp_z", 32'(dp_z), 32'(cur.z));
          chk("dp_mode", 32'(dp_mode), 32'(cur.mode));
        end
        if (rsp_valid && !prev_valid) chk("rsp_latency", 32'(mon_d), 32'(ITERS + 1));
        if (rsp_valid && prev_valid) begin
          chk("hold_id", 32'(rsp_id), 32'(pv_id));
          chk("hold_x", 32'(rsp_x), 32'(pv_x));
          chk("hold_y", 32'(rsp_y), 32'(pv_y));
          chk("hold_z", 32'(rsp_z), 32'(pv_z));
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_rsp.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
          end else begin
            got = exp_rsp.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(got.id));
            chk("rsp_x", 32'(rsp_x), 32'(got.x));
            chk("rsp_y", 32'(rsp_y), 32'(got.y));
            chk("rsp_z", 32'(rsp_z), 32'(got.z));
          end
          in_job = 0;
          hs_cyc = cyc;
        end
      end else begin
        chk("idle_iter", 32'(dp_iter), 32'd0);
        if (rsp_valid) chk("spurious_rsp", 32'(rsp_valid), 32'd0);
        if (req_ready != '0) begin
          if (exp_job.size() == 0) begin
            chk("unexpected_grant", 32'(req_ready), 32'd0);
          end else begin
            cur = exp_job.pop_front();
            chk("grant", 32'(req_ready), 32'(cur.gnt));
            if (gap_en) chk("grant_after_hs", 32'(cyc - hs_cyc), 32'd1);
            if (b2b_en && b2b_have) chk("b2b_gap", 32'(cyc - prev_gcyc), 32'(ITERS + 2));
            b2b_have  = 1;
            prev_gcyc = cyc;
            t_grant   = cyc;
            in_job    = 1;
          end
        end
      end
      prev_valid = rsp_valid;
      pv_id = rsp_id; pv_x = rsp_x; pv_y = rsp_y; pv_z = rsp_z;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(input string name, input int max);
    int n = 0;
    while (exp_job.size() != 0 && n < max) begin tick(); n++; end
    if (exp_job.size() != 0) begin
      chk({name, "_grant_timeout"}, 32'(exp_job.size()), 32'd0);
      exp_job.delete();
    end
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while ((exp_rsp.size() != 0 || in_job) && n < max) begin tick(); n++; end
    if (exp_rsp.size() != 0) begin
      chk({name, "_rsp_timeout"}, 32'(exp_rsp.size()), 32'd0);
      exp_rsp.delete();
    end
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_dp_sel"}, 32'(dp_sel), 32'd0);
    chk({tag, "_dp_iter"}, 32'(dp_iter), 32'd0);
    chk({tag, "_dp_mode"}, 32'(dp_mode), 32'd0);
    chk({tag, "_dp_x"}, 32'(dp_x), 32'd0);
    chk({tag, "_dp_y"}, 32'(dp_y), 32'd0);
    chk({tag, "_dp_z"}, 32'(dp_z), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_rsp_x"}, 32'(rsp_x), 32'd0);
    chk({tag, "_rsp_y"}, 32'(rsp_y), 32'd0);
    chk({tag, "_rsp_z"}, 32'(rsp_z), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; req_valid = '0; req_x = '0; req_y = '0; req_z = '0; req_mode = '0;
    rsp_ready = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) set_ops(k, '0, '0, '0, 1'b0);
    repeat (3) tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    // All four requesting, consumer always ready: grant order and back-to-back spacing.
    rsp_ready = 1'b1;
    for (int k = 0; k < int'(NREQ); k++)
      set_ops(k, 16'(16'h1000 * (k + 1)), 16'(16'h0100 * (k + 1)), 16'(16'h0011 * (k + 1)), 1'(k));
`ifdef CORDIC_SCHED_RR_EN
    expect_job(0, 1); expect_job(1, 1); expect_job(2, 1); expect_job(3, 1); expect_job(0, 1);
`else
    for (int i = 0; i < 5; i++) expect_job(0, 1);
`endif
    b2b_en = 1; b2b_have = 0;
    req_valid = 4'b1111;
    wait_grants("rr", 200);
    req_valid = '0;
    wait_drain("rr", 100);
    b2b_en = 0;

    // Single request on requester 2 with hand-computed result.
    set_ops(2, 16'h4000, 16'h0000, 16'h2000, 1'b0);
    exp_job.push_back('{4'b0100, 16'h4000, 16'h0000, 16'h2000, 1'b0});
    exp_rsp.push_back('{2'd2, 16'h400A, 16'h000A, 16'h1FF6});
    req_valid = 4'b0100;
    #1;
    chk("single_ready_same_cycle", 32'(req_ready), 32'h4);
    wait_grants("single", 20);
    req_valid = '0;
    wait_drain("single", 40);

    // Stalled consumer; requester 2 pulses and withdraws, requester 3 waits for the handshake.
    rsp_ready = 1'b0;
    set_ops(1, 16'h1234, 16'h5678, 16'h0F0F, 1'b1);
    set_ops(2, 16'hAAAA, 16'h5555, 16'h0001, 1'b0);
    set_ops(3, 16'h7FFF, 16'h8000, 16'hFFFF, 1'b1);
    expect_job(1, 1);
    req_valid = 4'b0010;
    wait_grants("stall", 20);
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    chk("stall_rsp_seen", 32'(rsp_valid), 32'd1);
    expect_job(3, 1);
    gap_en = 1;
    req_valid = 4'b1100;
    tick(); tick();
    req_valid = 4'b1000;
    tick(); tick(); tick();
    rsp_ready = 1'b1;
    wait_grants("after_hs", 20);
    req_valid = '0;
    gap_en = 0;
    wait_drain("after_hs", 40);

    // Reset mid-job at iteration 5; requester 0 stays pending and must be re-granted from pointer 0.
    set_ops(0, 16'h0102, 16'h0304, 16'h0506, 1'b1);
    set_ops(1, 16'h1111, 16'h2222, 16'h3333, 1'b0);
    expect_job(0, 0);
    expect_job(0, 1);
    req_valid = 4'b0011;
    n = 0;
    while (dp_iter != 4'd5 && n < 40) begin tick(); n++; end
    chk("abort_iter_seen", 32'(dp_iter), 32'd5);
    reset = 1'b1;
    tick();
    check_reset_vals("abort");
    tick();
    reset = 1'b0;
    wait_grants("regrant", 20);
    req_valid = '0;
    wait_drain("regrant", 40);

    chk("scoreboard_empty", 32'(exp_job.size() + exp_rsp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cordic_scheduler.md
CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one CORDIC datapath.
REQ-002 SHALL have parameter W, default 16: operand/result width.
REQ-003 SHALL have parameter ITERS, default 11: total iteration-index values, 0..ITERS-1.
REQ-004 SHALL have port clk  input  1: clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  NREQ: per-requester job request.
REQ-007 SHALL have port req_ready  output  NREQ: per-requester job accept, one-hot or zero.
REQ-008 SHALL have port req_x, req_y, req_z  input  NREQ*W each: operands, requester k at bits [k*W +: W].
REQ-009 SHALL have port req_mode  input  NREQ: 0 rotation, 1 vectoring.
REQ-010 SHALL have port dp_sel  output  1: datapath mux select, 0 loads operands, 1 feeds back iterates.
REQ-011 SHALL have port dp_iter  output  4: iteration index to the datapath.
REQ-012 SHALL have port dp_mode  output  1: mode of the job in flight.
REQ-013 SHALL have port dp_x, dp_y, dp_z  output  W each: operands of the job in flight.
REQ-014 SHALL have port dp_xo, dp_yo, dp_zo  input  W each: datapath outputs.
REQ-015 SHALL have port rsp_valid  output  1: result available.
REQ-016 SHALL have port rsp_ready  input  1: result consumer accept.
REQ-017 SHALL have port rsp_id  output  clog2(NREQ): index of the requester that owns the result.
REQ-018 SHALL have port rsp_x, rsp_y, rsp_z  output  W each: captured result.
REQ-019 SHALL have port busy  output  1: high in every state except IDLE.

Function
REQ-020 SHALL implement states IDLE, LOAD, ITER, DONE.
REQ-021 In IDLE with any req_valid set, SHALL assert req_ready to exactly one winner combinationally, latch its operands, mode and id, and go to LOAD.
REQ-022 SHALL assert req_ready only in IDLE; with no req_valid, req_ready SHALL be all zero and state SHALL stay IDLE.
REQ-023 LOAD SHALL last one cycle with dp_sel=0 and dp_iter=0.
REQ-024 ITER SHALL drive dp_sel=1 and dp_iter=1..ITERS-1, incrementing by one per cycle (10 cycles at default).
REQ-025 On the cycle dp_iter=ITERS-1, SHALL register dp_xo/dp_yo/dp_zo into rsp_x/y/z and go to DONE.
REQ-026 Latency SHALL be fixed: accept in cycle T, rsp_valid first high in cycle T+ITERS+1.
REQ-027 In DONE, SHALL hold rsp_valid=1 and stable rsp_* until rsp_ready=1, then return to IDLE next cycle.
REQ-028 SHALL not accept a new job before the pending response is consumed; a new job can be accepted one cycle after the response handshake at the earliest.
REQ-029 dp_x/y/z/mode SHALL be stable from LOAD through the final ITER cycle.
REQ-030 A requester dropping req_valid before grant SHALL lose nothing and SHALL not be granted.
REQ-031 dp_iter SHALL never exceed ITERS-1 and SHALL be 0 outside LOAD/ITER.

Reset
REQ-032 On reset, SHALL go to IDLE with req_ready=0, dp_sel=0, dp_iter=0, dp_mode=0, dp_x/y/z=0, rsp_valid=0, rsp_id=0, rsp_x/y/z=0, busy=0, and the round-robin pointer at 0.
REQ-033 Reset asserted mid-job SHALL abort the job with no response and no retry.

Configuration
REQ-034 With macro CORDIC_SCHED_RR_EN defined, arbitration SHALL be round-robin: search starts at pointer; after a grant to k, pointer becomes (k+1) mod NREQ.
REQ-035 Without CORDIC_SCHED_RR_EN, arbitration SHALL be fixed priority, lowest index wins, and no pointer register SHALL exist.

Structure
REQ-036 State encoding, mode encodings and the ITERS default SHALL live in shared package cordic_pkg.
REQ-037 The arbiter SHALL be sub-module cordic_rr_arbiter (request vector in, one-hot grant out, pointer internal, fixed-priority when the macro is absent).

Verification
REQ-038 Single request on req 2, x=0x4000, y=0, z=0x2000, mode 0 -> ready same cycle; LOAD 1 cycle; dp_iter 1..10; rsp_valid at T+12 with rsp_id=2 and rsp_* = model.
REQ-039 req_valid=4'b1111 held, RR build -> grants 0,1,2,3,0 in order; fixed build -> grants 0 every job.
REQ-040 rsp_ready low for 5 cycles in DONE -> rsp_* stable, req_ready=0 throughout, no new grant until one cycle after the handshake.
REQ-041 Reset pulsed at dp_iter=5 -> next cycle all outputs at reset values, no rsp_valid; pending requester re-granted afterward.
REQ-042 rsp_ready tied high, back-to-back requests -> exactly ITERS+2 cycles between consecutive grants.
